// File: rtl/led_glow_pkg.sv
// -----------------------------------------------------------------------------
// led_glow_pkg
// Shared constants for the LED breathing-glow block so board-level code can
// instantiate led_glow with the same defaults it was built around.
//   LED_GLOW_CNT_WIDTH  : default width of the free-running period counter
//   LED_GLOW_DUTY_WIDTH : default duty resolution in bits
// -----------------------------------------------------------------------------
package led_glow_pkg;

    localparam int LED_GLOW_CNT_WIDTH  = 24;
    localparam int LED_GLOW_DUTY_WIDTH = 4;

endpackage : led_glow_pkg

// File: rtl/led_glow_dsm.sv
// -----------------------------------------------------------------------------
// delta_sigma_mod
// First-order accumulator-carry modulator. Each edge the residue is added to
// the duty value. The carry out of that sum becomes the 1-bit output, so over
// 2^DUTY_WIDTH edges at a constant duty d the output is high on exactly d of
// them.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset, clears the accumulator
//   duty  : requested density, DUTY_WIDTH bits
//   pulse : modulated output, taken straight from the accumulator carry flop
// -----------------------------------------------------------------------------
module delta_sigma_mod
    import led_glow_pkg::*;
#(
    parameter int DUTY_WIDTH = LED_GLOW_DUTY_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DUTY_WIDTH-1:0] duty,
    output logic                  pulse
);

    // acc_q[DUTY_WIDTH] is the carry, the low bits are the residue.
    logic [DUTY_WIDTH:0] acc_d;
    logic [DUTY_WIDTH:0] acc_q;

    // Next accumulator value: the previous carry is dropped and the residue is added to the duty.
    always_comb begin
        acc_d = {1'b0, acc_q[DUTY_WIDTH-1:0]} + {1'b0, duty};
    end

    // Accumulator register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= {(DUTY_WIDTH+1){1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    // The carry flop drives the output directly, with no logic after the flop.
    assign pulse = acc_q[DUTY_WIDTH];

endmodule : delta_sigma_mod

// File: rtl/led_glow.sv
// -----------------------------------------------------------------------------
// led_glow
// Breathing LED driver. A free-running counter is folded into a triangle-wave
// duty value, and a delta-sigma modulator turns that value into a pulse density
// on the LED. The full breathe period is 2^CNT_WIDTH clocks. Each brightness
// level is held for 2^(CNT_WIDTH-1-DUTY_WIDTH) clocks. CNT_WIDTH must be at
// least DUTY_WIDTH+2.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset (counter and accumulator cleared)
//   LED : LED drive, 1 = on, taken directly from a flop
// -----------------------------------------------------------------------------
module led_glow
    import led_glow_pkg::*;
#(
    parameter int CNT_WIDTH  = LED_GLOW_CNT_WIDTH,
    parameter int DUTY_WIDTH = LED_GLOW_DUTY_WIDTH
) (
    input  logic clk,
    input  logic rst,
    output logic LED
);

    logic [CNT_WIDTH-1:0]  cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DUTY_WIDTH-1:0] ramp_s;
    logic [DUTY_WIDTH-1:0] duty_s;

    // Period counter increment. It wraps naturally at 2^CNT_WIDTH.
    always_comb begin
        cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    // Period counter register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Triangle mapping. The first half-period counts down from full brightness
    // and the second half counts back up. Because of this, duty is all-ones on
    // both sides of the counter wrap and the wrap does not glitch.
    always_comb begin
        ramp_s = cnt_q[CNT_WIDTH-2 -: DUTY_WIDTH];
        if (cnt_q[CNT_WIDTH-1]) begin
            duty_s = ramp_s;
        end else begin
            duty_s = ~ramp_s;
        end
    end

    delta_sigma_mod #(
        .DUTY_WIDTH (DUTY_WIDTH)
    ) u_dsm (
        .clk   (clk),
        .rst   (rst),
        .duty  (duty_s),
        .pulse (LED)
    );

endmodule : led_glow

// File: tb/tb_led_glow.sv
// -----------------------------------------------------------------------------
// tb_led_glow
// Scoreboard bench for led_glow at CNT_WIDTH=8 and DUTY_WIDTH=4. Each time the
// bench drives a clock step, it pushes the expected LED value (from its own
// reference model or from a fixed table) into a queue. It pops that value after
// the edge and compares it with the LED output.
// -----------------------------------------------------------------------------
module tb_led_glow;

    localparam int CW = 8;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic LED;

    int n_cmp = 0;
    int n_err = 0;

    logic          exp_q[$];
    logic [CW-1:0] m_cnt;
    logic [DW:0]   m_acc;

    led_glow #(
        .CNT_WIDTH  (CW),
        .DUTY_WIDTH (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .LED (LED)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_duty(input logic [CW-1:0] c);
        logic [DW-1:0] r;
        r = c[CW-2 -: DW];
        return c[CW-1] ? r : ~r;
    endfunction

    // Advance the model by one edge and queue the expected LED value. Then let
    // the DUT take the edge and compare #1 after it.
    task automatic step(input bit use_tbl, input logic tbl_led, input string tag);
        logic [DW:0] nxt;
        logic        exp_led;
        nxt   = {1'b0, m_acc[DW-1:0]} + {1'b0, model_duty(m_cnt)};
        m_cnt = m_cnt + 8'd1;
        m_acc = nxt;
        exp_q.push_back(use_tbl ? tbl_led : nxt[DW]);
        @(posedge clk);
        #1;
        exp_led = exp_q.pop_front();
        check_val(tag, 32'(LED), 32'(exp_led));
    endtask

    task automatic model_reset();
        m_cnt = 8'd0;
        m_acc = 5'd0;
        exp_q.delete();
    endtask

    logic [7:0]    su_pat;
    logic [7:0]    d14_pat;
    logic [DW-1:0] trough_res;
    int            ones;

    initial begin
        su_pat  = 8'hFE;   // LED after edges 1..8 = 0,1,1,1,1,1,1,1 (bit0 first)
        d14_pat = 8'hEF;   // LED after edges 9..16 = 1,1,1,1,0,1,1,1
        model_reset();

        // Power-on reset state
        #1;
        check_val("rst_led", 32'(LED), 32'd0);
        check_val("rst_cnt", 32'(dut.cnt_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Run a few edges, then assert reset asynchronously between edges
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "pre_async");
        #2;
        check_val("pre_async_led", 32'(LED), 32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        check_val("async_rst_led", 32'(LED), 32'd0);
        check_val("async_rst_cnt", 32'(dut.cnt_q), 32'd0);
        check_val("async_rst_acc", 32'(dut.u_dsm.acc_q), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Start-up: duty 15, then duty 14
        for (int i = 0; i < 8; i++) step(1'b1, su_pat[i], "startup");
        check_val("startup_residue", 32'(dut.u_dsm.acc_q[DW-1:0]), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b1, d14_pat[i], "duty14");

        // Zero-duty trough: pre-edge cnt 120..135
        while (m_cnt != 8'd120) step(1'b0, 1'b0, "run_to_120");
        trough_res = m_acc[DW-1:0];
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, "trough");
        check_val("trough_residue", 32'(dut.u_dsm.acc_q[DW-1:0]), 32'(trough_res));

        // Full period density and wrap continuity
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            if (m_cnt == 8'd255) check_val("duty_cnt255", 32'(dut.duty_s), 32'd15);
            if (m_cnt == 8'd0)   check_val("duty_cnt0", 32'(dut.duty_s), 32'd15);
            step(1'b0, 1'b0, "period");
            ones += int'(LED);
        end
        check_val("period_ones", 32'(ones), 32'd120);

        // Reset mid-operation at cnt=77 for 3 cycles
        while (m_cnt != 8'd77) step(1'b0, 1'b0, "run_to_77");
        check_val("cnt_at_77", 32'(dut.cnt_q), 32'd77);
        #2;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, su_pat[i], "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_led_glow
